// File: rtl/parking_gate_driver_if.sv
// -----------------------------------------------------------------------------
// parking_gate_driver_if
// Bundles the board-side sensors, the controller handshake and the request
// outputs of parking_gate_driver.
//   slave  : the driver side (sensors/full/door_open in, requests out)
//   master : the environment side (board I/O plus the `circuit` controller)
// Signals:
//   i_entry_sensor, i_exit_sensor : raw loop sensors (asynchronous, bouncy)
//   i_exit_spot[1:0]              : raw spot select for the leaving car
//   i_full, i_door_open           : status/ack from the controller
//   o_enter, o_exit               : one-cycle requests to the controller
//   o_switch[1:0]                 : spot code, stable around o_exit
//   o_busy, o_reject, o_ack_err   : status flags
//   o_ent_count, o_rej_count      : only with PARKING_GATE_STATS_EN defined
// -----------------------------------------------------------------------------
interface parking_gate_driver_if;
  logic       i_entry_sensor;
  logic       i_exit_sensor;
  logic [1:0] i_exit_spot;
  logic       i_full;
  logic       i_door_open;
  logic       o_enter;
  logic       o_exit;
  logic [1:0] o_switch;
  logic       o_busy;
  logic       o_reject;
  logic       o_ack_err;
`ifdef PARKING_GATE_STATS_EN
  logic [7:0] o_ent_count;
  logic [7:0] o_rej_count;

  modport slave (
    input  i_entry_sensor, i_exit_sensor, i_exit_spot, i_full, i_door_open,
    output o_enter, o_exit, o_switch, o_busy, o_reject, o_ack_err,
    output o_ent_count, o_rej_count
  );
  modport master (
    output i_entry_sensor, i_exit_sensor, i_exit_spot, i_full, i_door_open,
    input  o_enter, o_exit, o_switch, o_busy, o_reject, o_ack_err,
    input  o_ent_count, o_rej_count
  );
`else
  modport slave (
    input  i_entry_sensor, i_exit_sensor, i_exit_spot, i_full, i_door_open,
    output o_enter, o_exit, o_switch, o_busy, o_reject, o_ack_err
  );
  modport master (
    output i_entry_sensor, i_exit_sensor, i_exit_spot, i_full, i_door_open,
    input  o_enter, o_exit, o_switch, o_busy, o_reject, o_ack_err
  );
`endif
endinterface

// File: rtl/parking_gate_driver.sv
// -----------------------------------------------------------------------------
// parking_gate_driver
// Front end for the parking controller: synchronizes and debounces the entry
// and exit loop sensors and the exit spot select, then issues clean one-cycle
// enter/exit requests, waits for door_open as acknowledgment, and flags
// entries refused while the lot is full.
// Ports:
//   i_clk   : system clock, rising edge
//   i_rst_n : asynchronous active-low reset
//   bus     : parking_gate_driver_if.slave (sensors, handshake, requests)
// Parameters:
//   DB_CYCLES   : stable cycles needed to accept a sensor level change
//   ACK_TIMEOUT : cycles allowed in WAIT_ACK before ack_err (2..255)
//   HOLDOFF     : idle cycles forced after each transaction
// Optional feature macro: PARKING_GATE_STATS_EN adds saturating 8-bit
// counters of accepted enter pulses and reject pulses.
// -----------------------------------------------------------------------------
module parking_gate_driver #(
  parameter int DB_CYCLES   = 16,
  parameter int ACK_TIMEOUT = 64,
  parameter int HOLDOFF     = 8
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  parking_gate_driver_if.slave bus
);

  localparam int DBW  = $clog2(DB_CYCLES + 1);
  localparam int TMAX = (ACK_TIMEOUT > HOLDOFF) ? ACK_TIMEOUT : HOLDOFF;
  localparam int TW   = $clog2(TMAX + 1);

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_EXIT_SETUP = 3'd1,
    ST_EXIT_PULSE = 3'd2,
    ST_ENT_PULSE  = 3'd3,
    ST_WAIT_ACK   = 3'd4,
    ST_HOLD       = 3'd5
  } state_t;

  // Sensor vectors: bit 0 = entry, bit 1 = exit.
  logic [1:0]          r_sens_s1;
  logic [1:0]          r_sens_s2;
  logic [1:0]          r_spot_s1;
  logic [1:0]          r_spot_s2;
  logic [1:0]          r_db;
  logic [1:0][DBW-1:0] r_db_cnt;
  logic [1:0]          w_rise;
  logic                r_pend_ent;
  logic                r_pend_exit;
  state_t              r_state;
  state_t              w_state_nxt;
  logic [TW-1:0]       r_tmr;
  logic [1:0]          r_switch;
  logic                w_ack_to;

  // Two-flop synchronizers for the raw sensors and each spot-select bit.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sens_s1 <= 2'b00;
      r_sens_s2 <= 2'b00;
      r_spot_s1 <= 2'b00;
      r_spot_s2 <= 2'b00;
    end else begin
      r_sens_s1 <= {bus.i_exit_sensor, bus.i_entry_sensor};
      r_sens_s2 <= r_sens_s1;
      r_spot_s1 <= bus.i_exit_spot;
      r_spot_s2 <= r_spot_s1;
    end
  end

  // Debounce: the level flips on the DB_CYCLES-th consecutive mismatching cycle.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_db     <= 2'b00;
      r_db_cnt <= '{default: {DBW{1'b0}}};
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (r_sens_s2[i] != r_db[i]) begin
          if (r_db_cnt[i] == DBW'(DB_CYCLES - 1)) begin
            r_db[i]     <= r_sens_s2[i];
            r_db_cnt[i] <= {DBW{1'b0}};
          end else begin
            r_db_cnt[i] <= r_db_cnt[i] + DBW'(1);
          end
        end else begin
          r_db_cnt[i] <= {DBW{1'b0}};
        end
      end
    end
  end

  // A rising edge is flagged on the same cycle the debounced level flips to 1.
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      w_rise[i] = r_sens_s2[i] & ~r_db[i] & (r_db_cnt[i] == DBW'(DB_CYCLES - 1));
    end
  end

  // Pending flags: serving clears them; an edge arriving while set is dropped.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_pend_ent  <= 1'b0;
      r_pend_exit <= 1'b0;
    end else begin
      if (r_state == ST_EXIT_SETUP) begin
        r_pend_exit <= 1'b0;
      end else if (w_rise[1]) begin
        r_pend_exit <= 1'b1;
      end else begin
        r_pend_exit <= r_pend_exit;
      end
      if (r_state == ST_ENT_PULSE) begin
        r_pend_ent <= 1'b0;
      end else if (w_rise[0]) begin
        r_pend_ent <= 1'b1;
      end else begin
        r_pend_ent <= r_pend_ent;
      end
    end
  end

  assign w_ack_to = (r_tmr == TW'(ACK_TIMEOUT));

  // FSM next-state logic; exit wins over entry because it frees a spot.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (r_pend_exit) begin
          w_state_nxt = ST_EXIT_SETUP;
        end else if (r_pend_ent) begin
          w_state_nxt = ST_ENT_PULSE;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_EXIT_SETUP: w_state_nxt = ST_EXIT_PULSE;
      ST_EXIT_PULSE: w_state_nxt = ST_WAIT_ACK;
      ST_ENT_PULSE: begin
        if (bus.i_full) begin
          w_state_nxt = ST_HOLD;
        end else begin
          w_state_nxt = ST_WAIT_ACK;
        end
      end
      ST_WAIT_ACK: begin
        if (bus.i_door_open || w_ack_to) begin
          w_state_nxt = ST_HOLD;
        end else begin
          w_state_nxt = ST_WAIT_ACK;
        end
      end
      ST_HOLD: begin
        if (r_tmr == TW'(HOLDOFF)) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_state_nxt = ST_HOLD;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Per-state cycle timer: 1 on the first cycle of a state, saturating.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_tmr <= {TW{1'b0}};
    end else if (w_state_nxt != r_state) begin
      r_tmr <= TW'(1);
    end else if (r_tmr != TW'(TMAX)) begin
      r_tmr <= r_tmr + TW'(1);
    end else begin
      r_tmr <= r_tmr;
    end
  end

  // Spot code is captured on entry to EXIT_SETUP so it leads exit by a cycle.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_switch <= 2'b00;
    end else if ((r_state == ST_IDLE) && (w_state_nxt == ST_EXIT_SETUP)) begin
      r_switch <= r_spot_s2;
    end else begin
      r_switch <= r_switch;
    end
  end

  // Pulses decode straight from the state register so reset drops them at once.
  assign bus.o_exit    = (r_state == ST_EXIT_PULSE);
  assign bus.o_enter   = (r_state == ST_ENT_PULSE) & ~bus.i_full;
  assign bus.o_reject  = (r_state == ST_ENT_PULSE) & bus.i_full;
  assign bus.o_ack_err = (r_state == ST_WAIT_ACK) & ~bus.i_door_open & w_ack_to;
  assign bus.o_busy    = (r_state != ST_IDLE);
  assign bus.o_switch  = r_switch;

`ifdef PARKING_GATE_STATS_EN
  logic [7:0] r_ent_count;
  logic [7:0] r_rej_count;

  // Saturating counters of accepted entries and refused entries.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_ent_count <= 8'd0;
      r_rej_count <= 8'd0;
    end else begin
      if (bus.o_enter && (r_ent_count != 8'd255)) begin
        r_ent_count <= r_ent_count + 8'd1;
      end else begin
        r_ent_count <= r_ent_count;
      end
      if (bus.o_reject && (r_rej_count != 8'd255)) begin
        r_rej_count <= r_rej_count + 8'd1;
      end else begin
        r_rej_count <= r_rej_count;
      end
    end
  end

  assign bus.o_ent_count = r_ent_count;
  assign bus.o_rej_count = r_rej_count;
`endif

endmodule

// File: tb/tb_parking_gate_driver.sv
// -----------------------------------------------------------------------------
// tb_parking_gate_driver
// Directed bench for parking_gate_driver with DB_CYCLES=4, ACK_TIMEOUT=8,
// HOLDOFF=2. Inputs change 1 time unit after a rising edge; outputs are
// sampled at that same point, before any input change of the new cycle.
// With an input set just after edge h, the pending flag rises at edge h+6
// (2 sync + 4 debounce) and the FSM reacts at edge h+7.
// -----------------------------------------------------------------------------
module tb_parking_gate_driver;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  parking_gate_driver_if bus ();

  parking_gate_driver #(
    .DB_CYCLES  (4),
    .ACK_TIMEOUT(8),
    .HOLDOFF    (2)
  ) dut (
    .i_clk  (clk),
    .i_rst_n(rst_n),
    .bus    (bus)
  );

  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;
  int h        = 0;
  int n_ent    = 0;
  int n_exit   = 0;
  int n_rej    = 0;
  int n_ack    = 0;
  int t_ent    = -1;
  int t_exit   = -1;
  int t_rej    = -1;
  int t_ack    = -1;
  logic [1:0] prev_sw   = 2'b00;
  logic [1:0] sw_before = 2'b00;
  logic [1:0] sw_at     = 2'b00;

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, $signed(act), $signed(exp));
    end
  endtask

  // One clock: advance past the edge, then log any pulses seen this cycle.
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    if (bus.o_enter)   begin n_ent++;  t_ent = cyc; end
    if (bus.o_reject)  begin n_rej++;  t_rej = cyc; end
    if (bus.o_ack_err) begin n_ack++;  t_ack = cyc; end
    if (bus.o_exit) begin
      n_exit++;
      t_exit    = cyc;
      sw_before = prev_sw;
      sw_at     = bus.o_switch;
    end
    prev_sw = bus.o_switch;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic check_idle_outputs(input string tag);
    check_val({tag, "_pulses"}, {28'd0, bus.o_enter, bus.o_exit, bus.o_reject, bus.o_ack_err}, 32'd0);
    check_val({tag, "_busy"}, {31'd0, bus.o_busy}, 32'd0);
    check_val({tag, "_switch"}, {30'd0, bus.o_switch}, 32'd0);
  endtask

  initial begin
    bus.i_entry_sensor = 1'b0;
    bus.i_exit_sensor  = 1'b0;
    bus.i_exit_spot    = 2'b00;
    bus.i_full         = 1'b0;
    bus.i_door_open    = 1'b0;

    // Reset state, during and after reset.
    steps(3);
    check_idle_outputs("rst_held");
    rst_n = 1'b1;
    steps(2);
    check_idle_outputs("rst_released");

    // Bounce: 2-cycle toggles never survive the 4-cycle debounce.
    for (int i = 0; i < 10; i++) begin
      bus.i_entry_sensor = (i % 2 == 0);
      steps(2);
    end
    check_val("bounce_no_enter", n_ent, 0);
    bus.i_entry_sensor = 1'b1;
    h = cyc;
    steps(7);
    check_val("bounce_enter_count", n_ent, 1);
    check_val("bounce_enter_delay", t_ent - h, 7);
    step();                                   // h+8: WAIT_ACK, timer 1
    check_val("bounce_enter_single", {31'd0, bus.o_enter}, 32'd0);
    check_val("bounce_wait_busy", {31'd0, bus.o_busy}, 32'd1);
    step();                                   // h+9: WAIT_ACK, timer 2
    bus.i_door_open = 1'b1;
    step();                                   // h+10: HOLD
    bus.i_door_open = 1'b0;
    check_val("bounce_hold_busy", {31'd0, bus.o_busy}, 32'd1);
    steps(2);                                 // h+12: IDLE
    check_val("bounce_back_idle", {31'd0, bus.o_busy}, 32'd0);
    steps(10);
    check_val("bounce_no_retrigger", n_ent, 1);
    check_val("bounce_no_ack_err", n_ack, 0);
    bus.i_entry_sensor = 1'b0;
    steps(8);

    // Exit with spot 10; door_open already high when WAIT_ACK is entered.
    bus.i_exit_spot   = 2'b10;
    bus.i_exit_sensor = 1'b1;
    h = cyc;
    steps(8);
    check_val("exit_delay", t_exit - h, 8);
    check_val("exit_switch_before", {30'd0, sw_before}, 32'd2);
    check_val("exit_switch_during", {30'd0, sw_at}, 32'd2);
    bus.i_door_open = 1'b1;
    step();                                   // h+9: WAIT_ACK, ack seen at once
    check_val("exit_switch_after", {30'd0, bus.o_switch}, 32'd2);
    check_val("exit_falls", {31'd0, bus.o_exit}, 32'd0);
    step();                                   // h+10: HOLD
    bus.i_door_open = 1'b0;
    steps(2);                                 // h+12: IDLE
    check_val("exit_early_ack_idle", {31'd0, bus.o_busy}, 32'd0);
    check_val("exit_count", n_exit, 1);
    bus.i_exit_sensor = 1'b0;
    bus.i_exit_spot   = 2'b11;                // must not leak into switch on entry
    steps(8);

    // Full lot: entry refused, no enter, switch untouched.
    bus.i_full         = 1'b1;
    bus.i_entry_sensor = 1'b1;
    h = cyc;
    steps(7);
    check_val("full_reject_count", n_rej, 1);
    check_val("full_reject_delay", t_rej - h, 7);
    check_val("full_no_enter", n_ent, 1);
    step();                                   // h+8: HOLD
    check_val("full_reject_single", {31'd0, bus.o_reject}, 32'd0);
    check_val("full_switch_kept", {30'd0, bus.o_switch}, 32'd2);
    steps(2);                                 // h+10: IDLE
    check_val("full_back_idle", {31'd0, bus.o_busy}, 32'd0);
`ifdef PARKING_GATE_STATS_EN
    // One enter was accepted earlier in the bounce scenario.
    check_val("stats_rej_count", {24'd0, bus.o_rej_count}, 32'd1);
    check_val("stats_ent_count", {24'd0, bus.o_ent_count}, 32'd1);
`endif
    bus.i_full         = 1'b0;
    bus.i_entry_sensor = 1'b0;
    steps(8);

    // Simultaneous edges: exit first (h+8), entry after HOLD (h+13).
    bus.i_exit_spot    = 2'b01;
    bus.i_door_open    = 1'b1;
    bus.i_entry_sensor = 1'b1;
    bus.i_exit_sensor  = 1'b1;
    h = cyc;
    steps(17);
    check_val("simul_exit_delay", t_exit - h, 8);
    check_val("simul_enter_delay", t_ent - h, 13);
    check_val("simul_exit_count", n_exit, 2);
    check_val("simul_enter_count", n_ent, 2);
    check_val("simul_switch", {30'd0, bus.o_switch}, 32'd1);
    check_val("simul_idle", {31'd0, bus.o_busy}, 32'd0);
    bus.i_door_open    = 1'b0;
    bus.i_entry_sensor = 1'b0;
    bus.i_exit_sensor  = 1'b0;
    steps(8);

    // Timeout: no door_open, ack_err 8 cycles after enter.
    bus.i_entry_sensor = 1'b1;
    h = cyc;
    steps(18);
    check_val("to_enter_count", n_ent, 3);
    check_val("to_ack_count", n_ack, 1);
    check_val("to_ack_delay", t_ack - t_ent, 8);
    check_val("to_back_idle", {31'd0, bus.o_busy}, 32'd0);
    bus.i_entry_sensor = 1'b0;
    steps(8);

    // Reset in WAIT_ACK: everything drops, no ack_err, fresh edge afterwards.
    bus.i_entry_sensor = 1'b1;
    h = cyc;
    steps(10);                                // h+10: WAIT_ACK, timer 3
    check_val("rst_enter_count", n_ent, 4);
    check_val("rst_wait_busy", {31'd0, bus.o_busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    check_val("rst_busy_drop", {31'd0, bus.o_busy}, 32'd0);
    steps(3);
    check_idle_outputs("rst_mid");
    rst_n = 1'b1;
    h = cyc;
    steps(7);
    check_val("rst_fresh_enter_count", n_ent, 5);
    check_val("rst_fresh_enter_delay", t_ent - h, 7);
    bus.i_door_open = 1'b1;
    steps(5);
    check_val("rst_no_ack_err", n_ack, 1);
    check_val("rst_final_idle", {31'd0, bus.o_busy}, 32'd0);
`ifdef PARKING_GATE_STATS_EN
    // Counters restart from zero at reset.
    check_val("stats_ent_after_rst", {24'd0, bus.o_ent_count}, 32'd1);
    check_val("stats_rej_after_rst", {24'd0, bus.o_rej_count}, 32'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
